// File: rtl/uart_reg_writer.sv
// uart_reg_writer
//   UART receiver (8N1, or 8E1 when RX_PARITY_EN is defined) that decodes 2-byte
//   write commands and drives a register_file write port.
//   Command: header byte with bit 7 set carries the address in [ADDR_W-1:0];
//   the next clean byte is the data. A frame error drops any pending header.
//
//   Optional feature macro: RX_PARITY_EN (even parity bit between data and stop).
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rxd        in   serial input, idle high, asynchronous to clk
//   wd3        out  register write data
//   wa3        out  register write address
//   we3        out  register write enable, one-clk pulse
//   rx_byte    out  last byte received cleanly
//   byte_valid out  one-clk pulse, rx_byte updated
//   frame_err  out  one-clk pulse, bad stop bit (or bad parity)
//   busy       out  high from start detect to stop-bit sample
module uart_reg_writer #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] wd3,
  output logic [ADDR_W-1:0] wa3,
  output logic              we3,
  output logic [7:0]        rx_byte,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned DivRaw = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned Div    = (DivRaw == 0) ? 1 : DivRaw;
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned OsW    = $clog2(OVERSAMPLE);
  localparam int unsigned HalfOs = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    StArm,
    StIdle,
    StStart,
    StData,
`ifdef RX_PARITY_EN
    StParity,
`endif
    StStop
  } rx_state_e;

  typedef enum logic {PsHdr, PsDat} ps_state_e;

  // Input synchronizer; resets to the idle level so reset never looks like a start bit.
  logic rxd_s1_q, rxd_s2_q, rxd_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  assign rxd_sync = rxd_s2_q;

  // Oversample tick generator.
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            tick;

  assign tick      = (div_cnt_q == DivW'(Div - 1));
  assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

  // Receive FSM.
  rx_state_e        rx_state_q, rx_state_d;
  logic [OsW-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             os_last;
  logic             par_ok;

  assign os_last = (os_cnt_q == OsW'(OVERSAMPLE - 1));

`ifdef RX_PARITY_EN
  logic par_err_q, par_err_d;

  assign par_ok = ~par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    rx_state_d   = rx_state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef RX_PARITY_EN
    par_err_d    = par_err_q;
`endif
    unique case (rx_state_q)
      // Line must be seen high for a full bit time before any start is accepted.
      StArm: begin
        if (tick) begin
          if (!rxd_sync) begin
            os_cnt_d = '0;
          end else if (os_last) begin
            os_cnt_d   = '0;
            rx_state_d = StIdle;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      StIdle: begin
        if (tick && !rxd_sync) begin
          os_cnt_d   = '0;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (os_cnt_q == OsW'(HalfOs - 1)) begin
            os_cnt_d   = '0;
            bit_cnt_d  = '0;
            rx_state_d = rxd_sync ? StIdle : StData;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (os_last) begin
            os_cnt_d  = '0;
            shift_d   = {rxd_sync, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
              rx_state_d = StParity;
`else
              rx_state_d = StStop;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (os_last) begin
            os_cnt_d   = '0;
            // Even parity: the parity bit must equal the XOR of the data bits.
            par_err_d  = rxd_sync ^ (^shift_q);
            rx_state_d = StStop;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (os_last) begin
            os_cnt_d   = '0;
            rx_state_d = StIdle;
            if (rxd_sync && par_ok) begin
              rx_byte_d    = shift_q;
              byte_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: rx_state_d = StArm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= StArm;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Command parser: header then data; consumes registered byte_valid/frame_err.
  ps_state_e         ps_q, ps_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wa3_q, wa3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              we3_q, we3_d;

  always_comb begin
    ps_d   = ps_q;
    addr_d = addr_q;
    wa3_d  = wa3_q;
    wd3_d  = wd3_q;
    we3_d  = 1'b0;
    if (frame_err_q) begin
      ps_d = PsHdr;
    end else if (byte_valid_q) begin
      case (ps_q)
        PsHdr: begin
          if (rx_byte_q[7]) begin
            addr_d = rx_byte_q[ADDR_W-1:0];
            ps_d   = PsDat;
          end
        end
        // Any byte here is data, including ones with bit 7 set.
        PsDat: begin
          we3_d = 1'b1;
          wa3_d = addr_q;
          wd3_d = DATA_W'(rx_byte_q);
          ps_d  = PsHdr;
        end
        default: ps_d = PsHdr;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q   <= PsHdr;
      addr_q <= '0;
      wa3_q  <= '0;
      wd3_q  <= '0;
      we3_q  <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      addr_q <= addr_d;
      wa3_q  <= wa3_d;
      wd3_q  <= wd3_d;
      we3_q  <= we3_d;
    end
  end

  assign wd3        = wd3_q;
  assign wa3        = wa3_q;
  assign we3        = we3_q;
  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (rx_state_q != StArm) && (rx_state_q != StIdle);

endmodule

// File: tb/tb_uart_reg_writer.sv
// Bench for uart_reg_writer: 16 clk per bit. Expected receive events and register
// writes are queued when each frame is sent; a monitor pops and compares them.
module tb_uart_reg_writer;

  localparam int unsigned ClkFreq = 1_600_000;
  localparam int unsigned Baud    = 100_000;
  localparam int unsigned Os      = 16;
  localparam int unsigned DataW   = 8;
  localparam int unsigned AddrW   = 3;
  localparam int          BitClks = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             rxd;
  logic [DataW-1:0] wd3;
  logic [AddrW-1:0] wa3;
  logic             we3;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;
  logic             busy;

  always #5 clk = ~clk;

  uart_reg_writer #(
    .CLK_FREQ  (ClkFreq),
    .BAUD      (Baud),
    .OVERSAMPLE(Os),
    .DATA_W    (DataW),
    .ADDR_W    (AddrW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .wd3       (wd3),
    .wa3       (wa3),
    .we3       (we3),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct packed {logic is_err; logic [7:0] val;} rx_ev_t;
  typedef struct packed {logic [2:0] addr; logic [7:0] data;} wr_t;

  rx_ev_t exp_rx[$];
  wr_t    exp_wr[$];
  int     tests = 0;
  int     fails = 0;

  // Reference model of the command protocol.
  bit         m_hdr;
  logic [2:0] m_addr;
  wr_t        last_wr;

  function automatic void model_reset();
    m_hdr   = 1'b0;
    m_addr  = '0;
    last_wr = '0;
    exp_rx.delete();
    exp_wr.delete();
  endfunction

  function automatic void model_frame(logic [7:0] b, bit good);
    rx_ev_t ev;
    wr_t    w;
    ev.is_err = !good;
    ev.val    = good ? b : 8'h00;
    exp_rx.push_back(ev);
    if (!good) begin
      m_hdr = 1'b0;
    end else if (m_hdr) begin
      w.addr  = m_addr;
      w.data  = b;
      exp_wr.push_back(w);
      last_wr = w;
      m_hdr   = 1'b0;
    end else if (b[7]) begin
      m_hdr  = 1'b1;
      m_addr = b[2:0];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All drive tasks assume the caller sits 1 time unit after a rising edge.
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (BitClks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_bad,
                            input int gap);
    int g;
    g = gap;
`ifdef RX_PARITY_EN
    model_frame(b, stop_ok && !par_bad);
`else
    model_frame(b, stop_ok);
`endif
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef RX_PARITY_EN
    send_bit((^b) ^ par_bad);
`endif
    send_bit(stop_ok);
    // A low stop bit is followed by a full bit of idle so the line settles high.
    if (!stop_ok && g < BitClks) g = BitClks;
    idle(g);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wd3"},        32'(wd3),        32'h0);
    check({tag, " wa3"},        32'(wa3),        32'h0);
    check({tag, " we3"},        32'(we3),        32'h0);
    check({tag, " rx_byte"},    32'(rx_byte),    32'h0);
    check({tag, " byte_valid"}, 32'(byte_valid), 32'h0);
    check({tag, " frame_err"},  32'(frame_err),  32'h0);
    check({tag, " busy"},       32'(busy),       32'h0);
  endtask

  // Monitor: every output pulse must match the head of its queue.
  rx_ev_t mon_ev;
  wr_t    mon_wr;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (byte_valid) begin
          if (exp_rx.size() == 0) begin
            check("unexpected byte_valid (rx_byte)", 32'(rx_byte), 32'hFFFF_FFFF);
          end else begin
            mon_ev = exp_rx.pop_front();
            check("rx event is byte_valid", 32'(1'b0), 32'(mon_ev.is_err));
            if (!mon_ev.is_err) check("rx_byte", 32'(rx_byte), 32'(mon_ev.val));
          end
        end
        if (frame_err) begin
          if (exp_rx.size() == 0) begin
            check("unexpected frame_err", 32'(frame_err), 32'h0);
          end else begin
            mon_ev = exp_rx.pop_front();
            check("rx event is frame_err", 32'(1'b1), 32'(mon_ev.is_err));
          end
        end
        if (we3) begin
          if (exp_wr.size() == 0) begin
            check("unexpected we3 (wa3,wd3)", {21'h0, wa3, wd3}, 32'hFFFF_FFFF);
          end else begin
            mon_wr = exp_wr.pop_front();
            check("we3 wa3", 32'(wa3), 32'(mon_wr.addr));
            check("we3 wd3", 32'(wd3), 32'(mon_wr.data));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] b81;
    logic [7:0] rb;
    bit         seen;
    int         gap;

    rst = 1'b1;
    rxd = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: basic write.
    idle(20 * BitClks);
    send_frame(8'h85, 1'b1, 1'b0, 20);
    send_frame(8'h3C, 1'b1, 1'b0, 20);

    // 2: non-header discarded, then a write with a data byte that has bit 7 set.
    send_frame(8'h12, 1'b1, 1'b0, 20);
    send_frame(8'h87, 1'b1, 1'b0, 20);
    send_frame(8'hFF, 1'b1, 1'b0, 20);

    // 3: frame error drops the pending header.
    send_frame(8'h82, 1'b1, 1'b0, 20);
    send_frame(8'h44, 1'b0, 1'b0, 20);
    send_frame(8'h55, 1'b1, 1'b0, 20);

    // 4a: short low glitch is a false start.
    rxd = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("glitch busy raised", 32'(busy), 32'h1);
    rxd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("glitch busy cleared", 32'(busy), 32'h0);
    idle(40);

    // 4b: header, then reset in the middle of the next frame.
    send_frame(8'h82, 1'b1, 1'b0, 20);
    b81 = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b81[i]);
    rxd = b81[4];
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 4c: a low line after reset must not start a frame, nor a short high spell.
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (busy) seen = 1'b1;
    end
    rxd = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (busy) seen = 1'b1;
    end
    rxd = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy) seen = 1'b1;
    end
    check("no start while arming", 32'(seen), 32'h0);
    idle(40);
    send_frame(8'h33, 1'b1, 1'b0, 20);
    send_frame(8'h84, 1'b1, 1'b0, 20);
    send_frame(8'h66, 1'b1, 1'b0, 20);

    // 5: back-to-back frames.
    send_frame(8'h80, 1'b1, 1'b0, 0);
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 20);

`ifdef RX_PARITY_EN
    // 6: parity error on the data byte.
    send_frame(8'h84, 1'b1, 1'b0, 20);
    send_frame(8'h01, 1'b1, 1'b1, 20);
    send_frame(8'h22, 1'b1, 1'b0, 20);
`endif

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rb[7] = 1'b1;
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 24));
      send_frame(rb, $urandom_range(0, 11) != 0, $urandom_range(0, 11) == 0, gap);
    end

    idle(100);
    check("rx events outstanding", 32'(exp_rx.size()), 32'h0);
    check("writes outstanding",    32'(exp_wr.size()), 32'h0);
    check("wa3 holds last write",  32'(wa3), 32'(last_wr.addr));
    check("wd3 holds last write",  32'(wd3), 32'(last_wr.data));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
